// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage and instruction memory.
// A read is pending while imem_req is high; it completes on a cycle with imem_ready high.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads over a req/ready bus, absorbs
// decode stalls, takes ID redirects and drains reads that a redirect has made stale.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_in,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jump,
  input  logic [31:0]            jump_target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            instruction_out,
  output logic [31:0]            pc_out,
  output logic [31:0]            pc_add_out,
  output logic                   valid_out
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_add_q;
  logic        valid_q;

  logic        redirect;
  logic [31:0] target;
  logic        room;
  logic        accept;
  logic [31:0] pc_inc;

  always_comb begin
    redirect    = branch_taken | jump;
    target      = branch_taken ? branch_target : jump_target;
    target[1:0] = 2'b00;
    room        = !valid_q | !stall_in;
    accept      = (state == FETCH) & imem.imem_ready & room & !redirect;
    pc_inc      = pc + 32'd4;
  end

  // req/addr are registered alongside the state so the bus holds steady while a read is pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_add_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          req_q <= 1'b1;
          if (redirect) begin
            pc     <= target;
            addr_q <= target;
          end else begin
            addr_q <= pc;
          end
        end
        FETCH: begin
          if (imem.imem_ready && redirect) begin
            pc     <= target;
            addr_q <= target;
          end else if (!imem.imem_ready && redirect) begin
            // The pending read must still complete at its original address.
            drain_addr <= pc;
            pc         <= target;
            state      <= DRAIN;
          end else if (accept) begin
            pc     <= pc_inc;
            addr_q <= pc_inc;
          end
        end
        DRAIN: begin
          if (redirect) pc <= target;
          if (imem.imem_ready) begin
            state  <= FETCH;
            addr_q <= redirect ? target : pc;
          end
        end
        default: begin
          state  <= BOOT;
          req_q  <= 1'b0;
          addr_q <= pc;
        end
      endcase

      if (redirect) begin
        instr_q  <= '0;
        pc_q     <= '0;
        pc_add_q <= '0;
        valid_q  <= 1'b0;
      end else if (accept) begin
        instr_q  <= imem.imem_rdata;
        pc_q     <= pc;
        pc_add_q <= pc_inc;
        valid_q  <= 1'b1;
      end else if (!stall_in) begin
        instr_q  <= '0;
        pc_q     <= '0;
        pc_add_q <= '0;
        valid_q  <= 1'b0;
      end
    end
  end

  assign imem.imem_req   = req_q;
  assign imem.imem_addr  = addr_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_q;
  assign pc_add_out      = pc_add_q;
  assign valid_out       = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle-by-cycle vector table with a scoreboard of expected
// outputs, plus a hand-written asynchronous reset in the middle of a wait-stated read.
module tb_if_fetch_unit;

  localparam logic [31:0] P   = 32'h0040_0000;
  localparam logic [31:0] KEY = 32'h1234_5678;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] pc_add_out;
  logic        valid_out;

  if_fetch_unit_if imem ();

  if_fetch_unit #(.RESET_PC(P)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_target     (jump_target),
    .imem            (imem.master),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .pc_add_out      (pc_add_out),
    .valid_out       (valid_out)
  );

  // Memory contents are the address scrambled, so instruction and PC differ.
  assign imem.imem_rdata = imem.imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic        jmp;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
  } out_t;

  vec_t tbl [31];
  out_t sb [$];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(logic s, logic b, logic j, logic [31:0] bt, logic [31:0] jt,
                              logic r, logic ereq, logic [31:0] eaddr, logic ev, logic [31:0] epc);
    vec_t v;
    v.stall = s; v.br = b; v.jmp = j; v.bt = bt; v.jt = jt; v.rdy = r;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = ev; v.exp_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input out_t e);
    chk({tag, " valid_out"},       {31'd0, valid_out}, {31'd0, e.valid});
    chk({tag, " pc_out"},          pc_out,             e.valid ? e.pc : 32'd0);
    chk({tag, " pc_add_out"},      pc_add_out,         e.valid ? e.pc + 32'd4 : 32'd0);
    chk({tag, " instruction_out"}, instruction_out,    e.valid ? (e.pc ^ KEY) : 32'd0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input vec_t v, input string tag);
    out_t e;
    stall_in        = v.stall;
    branch_taken    = v.br;
    branch_target   = v.bt;
    jump            = v.jmp;
    jump_target     = v.jt;
    imem.imem_ready = v.rdy;
    e.valid = v.exp_valid;
    e.pc    = v.exp_pc;
    sb.push_back(e);
    #1;
    chk({tag, " imem_req"},  {31'd0, imem.imem_req}, {31'd0, v.exp_req});
    chk({tag, " imem_addr"}, imem.imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, expected one entry", tag);
    end else begin
      chk_outputs(tag, sb.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    out_t z;
    n_checks = 0;
    n_fail   = 0;
    z.valid  = 1'b0;
    z.pc     = '0;

    //           stall br jmp bt            jt            rdy req addr          valid pc
    tbl[0]  = mk(0, 0, 0, 0,            0,            1, 0, P,            0, 0);
    tbl[1]  = mk(0, 0, 0, 0,            0,            1, 1, P,            1, P);
    tbl[2]  = mk(0, 0, 0, 0,            0,            1, 1, P + 4,        1, P + 4);
    tbl[3]  = mk(0, 0, 0, 0,            0,            1, 1, P + 8,        1, P + 8);
    tbl[4]  = mk(1, 0, 0, 0,            0,            1, 1, P + 12,       1, P + 8);
    tbl[5]  = mk(1, 0, 0, 0,            0,            1, 1, P + 12,       1, P + 8);
    tbl[6]  = mk(1, 0, 0, 0,            0,            1, 1, P + 12,       1, P + 8);
    tbl[7]  = mk(0, 0, 0, 0,            0,            1, 1, P + 12,       1, P + 12);
    tbl[8]  = mk(0, 0, 0, 0,            0,            1, 1, P + 16,       1, P + 16);
    tbl[9]  = mk(0, 1, 0, 32'h0040_0100, 0,           1, 1, P + 20,       0, 0);
    tbl[10] = mk(0, 0, 0, 0,            0,            1, 1, 32'h0040_0100, 1, 32'h0040_0100);
    tbl[11] = mk(0, 0, 0, 0,            0,            0, 1, 32'h0040_0104, 0, 0);
    tbl[12] = mk(0, 0, 1, 0,            32'h0040_0200, 0, 1, 32'h0040_0104, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,            0,            0, 1, 32'h0040_0104, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,            0,            1, 1, 32'h0040_0104, 0, 0);
    tbl[15] = mk(0, 0, 0, 0,            0,            1, 1, 32'h0040_0200, 1, 32'h0040_0200);
    tbl[16] = mk(0, 1, 1, 32'h0040_0103, 32'h0040_0300, 1, 1, 32'h0040_0204, 0, 0);
    tbl[17] = mk(0, 0, 0, 0,            0,            1, 1, 32'h0040_0100, 1, 32'h0040_0100);
    tbl[18] = mk(1, 1, 0, 32'h0040_0180, 0,           1, 1, 32'h0040_0104, 0, 0);
    tbl[19] = mk(1, 0, 0, 0,            0,            1, 1, 32'h0040_0180, 1, 32'h0040_0180);
    tbl[20] = mk(1, 0, 0, 0,            0,            1, 1, 32'h0040_0184, 1, 32'h0040_0180);
    tbl[21] = mk(0, 0, 0, 0,            0,            0, 1, 32'h0040_0184, 0, 0);
    tbl[22] = mk(0, 0, 1, 0,            32'hFFFF_FFFC, 0, 1, 32'h0040_0184, 0, 0);
    tbl[23] = mk(0, 0, 0, 0,            0,            1, 1, 32'h0040_0184, 0, 0);
    tbl[24] = mk(0, 0, 0, 0,            0,            1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
    tbl[25] = mk(0, 0, 0, 0,            0,            1, 1, 32'h0000_0000, 1, 32'h0000_0000);
    tbl[26] = mk(0, 0, 1, 0,            P,            0, 1, 32'h0000_0004, 0, 0);
    tbl[27] = mk(0, 1, 0, 32'h0040_0040, 0,           0, 1, 32'h0000_0004, 0, 0);
    tbl[28] = mk(0, 0, 0, 0,            0,            1, 1, 32'h0000_0004, 0, 0);
    tbl[29] = mk(0, 0, 0, 0,            0,            1, 1, 32'h0040_0040, 1, 32'h0040_0040);
    tbl[30] = mk(0, 0, 0, 0,            0,            0, 1, 32'h0040_0044, 0, 0);

    reset           = 1'b0;
    stall_in        = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = '0;
    jump            = 1'b0;
    jump_target     = '0;
    imem.imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset imem_req",  {31'd0, imem.imem_req}, 32'd0);
    chk("reset imem_addr", imem.imem_addr, P);
    chk_outputs("reset", z);
    reset = 1'b1;

    for (int unsigned i = 0; i < 31; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a wait-stated read, away from any clock edge.
    imem.imem_ready = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midwait imem_req",  {31'd0, imem.imem_req}, 32'd0);
    chk("midwait imem_addr", imem.imem_addr, P);
    chk_outputs("midwait", z);
    @(negedge clk);
    reset = 1'b1;
    step(mk(0, 0, 0, 0, 0, 1, 0, P,     0, 0),     "restart0");
    step(mk(0, 0, 0, 0, 0, 1, 1, P,     1, P),     "restart1");
    step(mk(0, 0, 0, 0, 0, 1, 1, P + 4, 1, P + 4), "restart2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
